// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU codes, sequencer states and the datapath strobe bundle.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned ALU_W  = 5;
  localparam int unsigned WCNT_W = 4;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2,
    S_EX3, S_EX4, S_EX5, S_EX6, S_EX7,
    S_HALT
  } state_t;

  localparam int unsigned STATE_W = $bits(state_t);

  typedef struct packed {
    logic pcout;
    logic marin;
    logic incpc;
    logic zloin;
    logic zloout;
    logic pcin;
    logic read;
    logic mdrin;
    logic mdrout;
    logic irin;
    logic gra;
    logic grb;
    logic grc;
    logic baout;
    logic rin;
    logic rout;
    logic yin;
    logic cout;
    logic ram_write;
  } strobes_t;

  localparam int unsigned STROBE_W = $bits(strobes_t);

  // Opcodes that continue past FETCH2 into the execute states
  function automatic logic is_exec_op(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) ||
           (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe/ALU decode from the registered state and latched opcode.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0]  state,
  input  logic [OP_W-1:0]     op_q,
  input  logic                fetch_first,
  output logic [STROBE_W-1:0] strobes,
  output logic [ALU_W-1:0]    alu_opcode
);

  state_t   st;
  strobes_t s;
  logic     addr_class;

  assign st         = state_t'(state);
  assign addr_class = (op_q == OP_LD) || (op_q == OP_LDI) || (op_q == OP_ST);
  assign strobes    = s;

  always_comb begin
    s          = '0;
    alu_opcode = ALU_ADD;
    unique case (st)
      S_FETCH0: begin
        s.pcout = 1'b1;
        s.marin = 1'b1;
        s.incpc = 1'b1;
        s.zloin = 1'b1;
      end
      S_FETCH1: begin
        s.zloout = 1'b1;
        s.pcin   = fetch_first;
        s.read   = 1'b1;
        s.mdrin  = 1'b1;
      end
      S_FETCH2: begin
        s.mdrout = 1'b1;
        s.irin   = 1'b1;
      end
      // Base register into Y; address ops use the BA bus so R0 reads as zero
      S_EX3: begin
        s.grb   = 1'b1;
        s.yin   = 1'b1;
        s.baout = addr_class;
        s.rout  = ~addr_class;
      end
      S_EX4: begin
        s.cout  = 1'b1;
        s.zloin = 1'b1;
        if (op_q == OP_ANDI)     alu_opcode = ALU_AND;
        else if (op_q == OP_ORI) alu_opcode = ALU_OR;
      end
      S_EX5: begin
        s.zloout = 1'b1;
        if ((op_q == OP_LD) || (op_q == OP_ST)) begin
          s.marin = 1'b1;
        end else begin
          s.gra = 1'b1;
          s.rin = 1'b1;
        end
      end
      S_EX6: begin
        s.mdrin = 1'b1;
        if (op_q == OP_LD) begin
          s.read = 1'b1;
        end else begin
          s.gra  = 1'b1;
          s.rout = 1'b1;
        end
      end
      S_EX7: begin
        if (op_q == OP_LD) begin
          s.mdrout = 1'b1;
          s.gra    = 1'b1;
          s.rin    = 1'b1;
        end else begin
          s.ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ldst_ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the load/store/immediate class.
module ldst_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IR_W     = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IR_W-1:0]  IR,
  input  logic             Stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             ZLOin,
  output logic             ZLOout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             BAout,
  output logic             Rin,
  output logic             Rout,
  output logic             Yin,
  output logic             Cout,
  output logic             RAM_write,
  output logic [ALU_W-1:0] ALU_opcode,
  output logic             Run,
  output logic             Illegal
);

  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(MEM_WAIT - 1);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [OP_W-1:0]     ir_op;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                run_q, run_d;
  logic                illegal_q, illegal_d;
  logic [STROBE_W-1:0] dec_strobes;
  logic [ALU_W-1:0]    dec_alu;
  strobes_t            so;
  logic                unused_ir_bits;

  assign ir_op          = IR[IR_W-1 -: OP_W];
  assign unused_ir_bits = ^IR[IR_W-OP_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_FETCH0;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wcnt_q    <= '0;
      op_q      <= '0;
      run_q     <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
      if (state_q == S_FETCH2) op_q <= ir_op;
    end
  end

  // Next state; memory states reload the wait counter on entry and leave at zero
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    run_d     = run_q;
    illegal_d = 1'b0;
    unique case (state_q)
      S_FETCH0: if (!Stop) begin
        state_d = S_FETCH1;
        wcnt_d  = WAIT_INIT;
      end
      S_FETCH1: begin
        if (wcnt_q == '0) state_d = S_FETCH2;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_FETCH2: begin
        if (is_exec_op(ir_op)) begin
          state_d = S_EX3;
        end else if (ir_op == OP_NOP) begin
          state_d = S_FETCH0;
        end else if (ir_op == OP_HALT) begin
          state_d = S_HALT;
          run_d   = 1'b0;
        end else begin
          state_d   = S_FETCH0;
          illegal_d = 1'b1;
        end
      end
      S_EX3: state_d = S_EX4;
      S_EX4: state_d = S_EX5;
      S_EX5: begin
        if ((op_q == OP_LD) || (op_q == OP_ST)) begin
          state_d = S_EX6;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = S_FETCH0;
        end
      end
      S_EX6: begin
        if ((op_q != OP_LD) || (wcnt_q == '0)) begin
          state_d = S_EX7;
          wcnt_d  = WAIT_INIT;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_EX7: begin
        if ((op_q == OP_LD) || (wcnt_q == '0)) state_d = S_FETCH0;
        else                                   wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
  end

  ctrl_decode u_decode (
    .state       (STATE_W'(state_q)),
    .op_q        (op_q),
    .fetch_first (wcnt_q == WAIT_INIT),
    .strobes     (dec_strobes),
    .alu_opcode  (dec_alu)
  );

  // Strobe outputs; clr and a held FETCH0 silence the datapath
  always_comb begin
    so = strobes_t'(dec_strobes);
    if (clr || ((state_q == S_FETCH0) && Stop)) so = '0;
    PCout      = so.pcout;
    MARin      = so.marin;
    IncPC      = so.incpc;
    ZLOin      = so.zloin;
    ZLOout     = so.zloout;
    PCin       = so.pcin;
    Read       = so.read;
    MDRin      = so.mdrin;
    MDRout     = so.mdrout;
    IRin       = so.irin;
    Gra        = so.gra;
    Grb        = so.grb;
    Grc        = so.grc;
    BAout      = so.baout;
    Rin        = so.rin;
    Rout       = so.rout;
    Yin        = so.yin;
    Cout       = so.cout;
    RAM_write  = so.ram_write;
    ALU_opcode = dec_alu;
  end

  assign Run     = run_q;
  assign Illegal = illegal_q;

endmodule

// File: tb/tb_ldst_ctrl_sequencer.sv
// Randomized and directed bench for ldst_ctrl_sequencer at MEM_WAIT=1 and MEM_WAIT=3.
module tb_ldst_ctrl_sequencer;

  localparam logic [18:0] PCOUT  = 19'd1 << 18;
  localparam logic [18:0] MARIN  = 19'd1 << 17;
  localparam logic [18:0] INCPC  = 19'd1 << 16;
  localparam logic [18:0] ZLOIN  = 19'd1 << 15;
  localparam logic [18:0] ZLOOUT = 19'd1 << 14;
  localparam logic [18:0] PCIN   = 19'd1 << 13;
  localparam logic [18:0] READ   = 19'd1 << 12;
  localparam logic [18:0] MDRIN  = 19'd1 << 11;
  localparam logic [18:0] MDROUT = 19'd1 << 10;
  localparam logic [18:0] IRIN   = 19'd1 << 9;
  localparam logic [18:0] GRA    = 19'd1 << 8;
  localparam logic [18:0] GRB    = 19'd1 << 7;
  localparam logic [18:0] BAOUT  = 19'd1 << 5;
  localparam logic [18:0] RIN    = 19'd1 << 4;
  localparam logic [18:0] ROUT   = 19'd1 << 3;
  localparam logic [18:0] YIN    = 19'd1 << 2;
  localparam logic [18:0] COUT   = 19'd1 << 1;
  localparam logic [18:0] RAMWR  = 19'd1;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADDI = 5'b01100;
  localparam logic [4:0] ANDI = 5'b01101, ORI = 5'b01110, NOP = 5'b11010, HALT = 5'b11011;
  localparam logic [4:0] A_ADD = 5'b00011, A_AND = 5'b00101, A_OR = 5'b00110;

  typedef struct packed {
    logic [18:0] s;
    logic [4:0]  alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir   [2];
  logic        stop [2];
  wire  [18:0] s0, s1;
  wire  [4:0]  a0, a1;
  wire         r0, r1, i0, i1;
  logic [18:0] str  [2];
  logic [4:0]  alu  [2];
  logic        run  [2];
  logic        ill  [2];

  int   mw [2] = '{1, 3};
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic exp_run [2];
  logic exp_ill_last;
  int   last_sel;

  always #5 clk = ~clk;

  assign str[0] = s0;  assign str[1] = s1;
  assign alu[0] = a0;  assign alu[1] = a1;
  assign run[0] = r0;  assign run[1] = r1;
  assign ill[0] = i0;  assign ill[1] = i1;

  ldst_ctrl_sequencer #(.MEM_WAIT(1), .IR_W(32)) u_dut_m1 (
    .clk(clk), .clr(clr), .IR(ir[0]), .Stop(stop[0]),
    .PCout(s0[18]), .MARin(s0[17]), .IncPC(s0[16]), .ZLOin(s0[15]), .ZLOout(s0[14]),
    .PCin(s0[13]), .Read(s0[12]), .MDRin(s0[11]), .MDRout(s0[10]), .IRin(s0[9]),
    .Gra(s0[8]), .Grb(s0[7]), .Grc(s0[6]), .BAout(s0[5]), .Rin(s0[4]), .Rout(s0[3]),
    .Yin(s0[2]), .Cout(s0[1]), .RAM_write(s0[0]),
    .ALU_opcode(a0), .Run(r0), .Illegal(i0)
  );

  ldst_ctrl_sequencer #(.MEM_WAIT(3), .IR_W(32)) u_dut_m3 (
    .clk(clk), .clr(clr), .IR(ir[1]), .Stop(stop[1]),
    .PCout(s1[18]), .MARin(s1[17]), .IncPC(s1[16]), .ZLOin(s1[15]), .ZLOout(s1[14]),
    .PCin(s1[13]), .Read(s1[12]), .MDRin(s1[11]), .MDRout(s1[10]), .IRin(s1[9]),
    .Gra(s1[8]), .Grb(s1[7]), .Grc(s1[6]), .BAout(s1[5]), .Rin(s1[4]), .Rout(s1[3]),
    .Yin(s1[2]), .Cout(s1[1]), .RAM_write(s1[0]),
    .ALU_opcode(a1), .Run(r1), .Illegal(i1)
  );

  function automatic logic is_known(input logic [4:0] op);
    return op inside {LD, LDI, ST, ADDI, ANDI, ORI, NOP, HALT};
  endfunction

  function automatic void push(input logic [18:0] s, input logic [4:0] a);
    exp_t e;
    e.s   = s;
    e.alu = a;
    exp_q.push_back(e);
  endfunction

  // Reference: per-cycle strobe list of one instruction, from the instruction-level rules
  task automatic build_model(input logic [4:0] op, input int m);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZLOIN, A_ADD);
    for (int k = 0; k < m; k++) push(ZLOOUT | READ | MDRIN | ((k == 0) ? PCIN : 19'd0), A_ADD);
    push(MDROUT | IRIN, A_ADD);
    if (op inside {LD, LDI, ST, ADDI, ANDI, ORI}) begin
      push(GRB | YIN | ((op inside {LD, LDI, ST}) ? BAOUT : ROUT), A_ADD);
      push(COUT | ZLOIN, (op == ANDI) ? A_AND : ((op == ORI) ? A_OR : A_ADD));
      if (op == LD) begin
        push(ZLOOUT | MARIN, A_ADD);
        for (int k = 0; k < m; k++) push(READ | MDRIN, A_ADD);
        push(MDROUT | GRA | RIN, A_ADD);
      end else if (op == ST) begin
        push(ZLOOUT | MARIN, A_ADD);
        push(GRA | ROUT | MDRIN, A_ADD);
        for (int k = 0; k < m; k++) push(RAMWR, A_ADD);
      end else begin
        push(ZLOOUT | GRA | RIN, A_ADD);
      end
    end
  endtask

  // Runs one instruction on instance sel from FETCH0, comparing every cycle
  task automatic run_instr(input int sel, input logic [31:0] iv, input int stop_at, input int clr_at);
    logic [4:0] op;
    logic       aborted;
    logic       e_ill;
    op      = iv[31:27];
    aborted = 1'b0;
    build_model(op, mw[sel]);
    ir[sel]   = iv;
    stop[sel] = 1'b0;
    for (int i = 0; i < exp_q.size() && !aborted; i++) begin
      #1;
      e_ill  = (i == 0) && (sel == last_sel) && exp_ill_last;
      checks += 4;
      if (str[sel] !== exp_q[i].s) begin
        errors++;
        $display("FAIL strobes inst%0d op=%b cyc%0d: got %b expected %b", sel, op, i, str[sel], exp_q[i].s);
      end
      if (alu[sel] !== exp_q[i].alu) begin
        errors++;
        $display("FAIL alu inst%0d op=%b cyc%0d: got %b expected %b", sel, op, i, alu[sel], exp_q[i].alu);
      end
      if (run[sel] !== exp_run[sel]) begin
        errors++;
        $display("FAIL run inst%0d op=%b cyc%0d: got %b expected %b", sel, op, i, run[sel], exp_run[sel]);
      end
      if (ill[sel] !== e_ill) begin
        errors++;
        $display("FAIL illegal inst%0d op=%b cyc%0d: got %b expected %b", sel, op, i, ill[sel], e_ill);
      end
      if (i == stop_at) stop[sel] = 1'b1;
      if (i == clr_at) begin
        clr       = 1'b1;
        stop[0]   = 1'b1;
        stop[1]   = 1'b1;
        aborted   = 1'b1;
      end
      @(negedge clk);
    end
    stop[sel] = 1'b1;
    if (aborted) begin
      last_sel     = -1;
      exp_ill_last = 1'b0;
    end else begin
      last_sel     = sel;
      exp_ill_last = !is_known(op);
      if (op == HALT) exp_run[sel] = 1'b0;
    end
  endtask

  // Called one cycle after clr was raised: checks the cleared state and releases clr
  task automatic finish_clear(input int sel);
    #1;
    checks += 2;
    if (str[sel] !== 19'd0) begin
      errors++;
      $display("FAIL clr_strobes inst%0d: got %b expected 0", sel, str[sel]);
    end
    if (run[sel] !== 1'b1) begin
      errors++;
      $display("FAIL clr_run inst%0d: got %b expected 1", sel, run[sel]);
    end
    clr = 1'b0;
    #1;
    checks += 2;
    if (str[sel] !== 19'd0) begin
      errors++;
      $display("FAIL held_fetch0 inst%0d: got %b expected 0", sel, str[sel]);
    end
    if (ill[sel] !== 1'b0) begin
      errors++;
      $display("FAIL clr_illegal inst%0d: got %b expected 0", sel, ill[sel]);
    end
    exp_run[0] = 1'b1;
    exp_run[1] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; stop[0] = 1'b1; stop[1] = 1'b1; ir[0] = '0; ir[1] = '0;
    exp_run[0] = 1'b1; exp_run[1] = 1'b1; exp_ill_last = 1'b0; last_sel = -1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      #1;
      checks += 3;
      if (str[s] !== 19'd0) begin errors++; $display("FAIL reset_strobes inst%0d: got %b expected 0", s, str[s]); end
      if (run[s] !== 1'b1)  begin errors++; $display("FAIL reset_run inst%0d: got %b expected 1", s, run[s]); end
      if (ill[s] !== 1'b0)  begin errors++; $display("FAIL reset_illegal inst%0d: got %b expected 0", s, ill[s]); end
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ld_st();
    run_instr(0, 32'h00900054, -1, -1);
    run_instr(0, 32'h1218001F, -1, -1);
    run_instr(1, 32'h00900054, -1, -1);
    run_instr(1, 32'h1218001F, -1, -1);
  endtask

  task automatic test_alu_ops_wait3();
    run_instr(1, 32'h619FFFFB, -1, -1);
    run_instr(1, {ANDI, 27'h0123456}, -1, -1);
    run_instr(1, {ORI, 27'h7654321}, -1, -1);
    run_instr(0, {LDI, 27'h0000ABC}, -1, -1);
  endtask

  task automatic test_illegal();
    run_instr(0, 32'hF8000000, -1, -1);
    run_instr(0, {NOP, 27'h0}, -1, -1);
    run_instr(0, {NOP, 27'h0}, -1, -1);
  endtask

  task automatic test_halt();
    run_instr(1, 32'hD8000000, -1, -1);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks += 2;
      if (run[1] !== 1'b0) begin errors++; $display("FAIL halt_run cyc%0d: got %b expected 0", c, run[1]); end
      if (str[1] !== 19'd0) begin errors++; $display("FAIL halt_strobes cyc%0d: got %b expected 0", c, str[1]); end
      @(negedge clk);
    end
    clr = 1'b1;
    last_sel = -1;
    exp_ill_last = 1'b0;
    @(negedge clk);
    finish_clear(1);
    run_instr(1, {NOP, 27'h0}, -1, -1);
  endtask

  task automatic test_stop_mid_ld();
    run_instr(0, 32'h00900054, 5, -1);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (str[0] !== 19'd0) begin errors++; $display("FAIL stop_hold cyc%0d: got %b expected 0", c, str[0]); end
      @(negedge clk);
    end
    run_instr(0, {LDI, 27'h1}, -1, -1);
  endtask

  task automatic test_clr_mid_st();
    run_instr(1, 32'h1218001F, -1, mw[1] + 5);
    finish_clear(1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (str[1][0] !== 1'b0) begin errors++; $display("FAIL clr_ramwrite cyc%0d: got %b expected 0", c, str[1][0]); end
      @(negedge clk);
    end
    run_instr(1, {NOP, 27'h0}, -1, -1);
  endtask

  task automatic test_random();
    logic [4:0] ops [7] = '{LD, LDI, ST, ADDI, ANDI, ORI, NOP};
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 5'($urandom); while (is_known(op));
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr(int'($urandom_range(0, 1)), {op, 27'($urandom)}, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ld_st();
    test_alu_ops_wait3();
    test_illegal();
    test_halt();
    test_stop_mid_ld();
    test_clr_mid_st();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
